// File: rtl/crc8_frame_rx.sv
// Deserializes 24-bit frames (16-bit payload + CRC-8, MSB first) and reports good/CRC/length results.
// Results are registered one cycle after cs_n rises; the serial input is never stalled.
module crc8_frame_rx #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic                 bit_vld,
  input  logic                 bit_in,
  input  logic                 err_cnt_clr,
  output logic [15:0]          rx_data,
  output logic                 rx_vld,
  output logic                 crc_err,
  output logic                 len_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] crc_err_cnt
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ABORT} state_t;

  state_t                r_state, w_state_nxt;
  logic [23:0]           r_sreg, w_sreg_nxt;
  logic [4:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic [IDLE_W-1:0]     r_idle_cnt, w_idle_cnt_nxt;
  logic [15:0]           r_rx_data, w_rx_data_nxt;
  logic                  r_rx_vld, w_rx_vld_nxt;
  logic                  r_crc_err, w_crc_err_nxt;
  logic                  r_len_err, w_len_err_nxt;
  logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;
  logic                  w_crc_ok;

  // Bit-serial LFSR unrolled over the payload: poly 0x2F, seed 0xFF, no reflection or final XOR.
  function automatic logic [7:0] crc8_16(input logic [15:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ 8'h2F) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign w_crc_ok = (crc8_16(r_sreg[23:8]) == r_sreg[7:0]);

  always_comb begin
    w_state_nxt    = r_state;
    w_sreg_nxt     = r_sreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    w_rx_data_nxt  = r_rx_data;
    w_rx_vld_nxt   = 1'b0;
    w_crc_err_nxt  = 1'b0;
    w_len_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!cs_n) begin
          w_state_nxt    = S_SHIFT;
          w_sreg_nxt     = {23'd0, bit_vld & bit_in};
          w_bit_cnt_nxt  = bit_vld ? 5'd1 : 5'd0;
          w_idle_cnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (cs_n) begin
          w_state_nxt = S_IDLE;
          if (r_bit_cnt != 5'd24) begin
            w_len_err_nxt = 1'b1;
          end else if (w_crc_ok) begin
            w_rx_vld_nxt  = 1'b1;
            w_rx_data_nxt = r_sreg[23:8];
          end else begin
            w_crc_err_nxt = 1'b1;
          end
        end else if (bit_vld) begin
          w_sreg_nxt     = {r_sreg[22:0], bit_in};
          w_idle_cnt_nxt = '0;
          // 25 encodes "more than 24 bits"
          if (r_bit_cnt != 5'd25) w_bit_cnt_nxt = r_bit_cnt + 5'd1;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_idle_cnt_nxt = IDLE_MAX;
          w_len_err_nxt  = 1'b1;
          w_state_nxt    = S_ABORT;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      S_ABORT: begin
        if (cs_n) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_err_cnt_nxt = r_err_cnt;
    if (err_cnt_clr) begin
      w_err_cnt_nxt = '0;
    end else if (w_crc_err_nxt && (r_err_cnt != '1)) begin
      w_err_cnt_nxt = r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_idle_cnt <= '0;
      r_rx_data  <= '0;
      r_rx_vld   <= 1'b0;
      r_crc_err  <= 1'b0;
      r_len_err  <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_sreg     <= w_sreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_vld   <= w_rx_vld_nxt;
      r_crc_err  <= w_crc_err_nxt;
      r_len_err  <= w_len_err_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_vld      = r_rx_vld;
  assign crc_err     = r_crc_err;
  assign len_err     = r_len_err;
  assign busy        = (r_state != S_IDLE);
  assign crc_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_crc8_frame_rx.sv
// Bench for crc8_frame_rx: frame-level reference model checked every cycle, plus directed literal checks.
module tb_crc8_frame_rx;

  localparam int TO      = 1024;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk, rst_n, cs_n, bit_vld, bit_in, err_cnt_clr;
  logic [15:0]   rx_data;
  logic          rx_vld, crc_err, len_err, busy;
  logic [CW-1:0] crc_err_cnt;

  crc8_frame_rx #(.TIMEOUT_CYC(TO), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .bit_vld(bit_vld), .bit_in(bit_in),
    .err_cnt_clr(err_cnt_clr), .rx_data(rx_data), .rx_vld(rx_vld), .crc_err(crc_err),
    .len_err(len_err), .busy(busy), .crc_err_cnt(crc_err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int close_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference CRC as polynomial long division of the augmented message; the seed
  // is equivalent to inverting the first 8 message bits.
  function automatic logic [7:0] ref_crc(input logic [15:0] p);
    logic [23:0] r;
    r = {p ^ 16'hFF00, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (r[i]) r = r ^ (24'h12F << (i - 8));
    end
    return r[7:0];
  endfunction

  // Frame-level reference model
  bit          in_frame, dropped;
  int          quiet;
  logic        mbits[$];
  logic        e_vld, e_crc, e_len;
  logic [15:0] e_data;
  int          e_cnt;

  task automatic judge();
    logic [23:0] word;
    word = '0;
    if (mbits.size() != 24) begin
      e_len = 1'b1;
    end else begin
      foreach (mbits[k]) word = {word[22:0], mbits[k]};
      if (ref_crc(word[23:8]) == word[7:0]) begin
        e_vld  = 1'b1;
        e_data = word[23:8];
      end else begin
        e_crc = 1'b1;
        if (e_cnt != CNT_MAX) e_cnt++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      in_frame = 0; dropped = 0; quiet = 0; mbits.delete();
      e_vld = 0; e_crc = 0; e_len = 0; e_data = '0; e_cnt = 0;
    end else begin
      e_vld = 0; e_crc = 0; e_len = 0;
      if (!in_frame) begin
        if (!cs_n) begin
          in_frame = 1; dropped = 0; quiet = 0; mbits.delete();
          if (bit_vld) mbits.push_back(bit_in);
        end
      end else if (cs_n) begin
        in_frame = 0;
        if (!dropped) judge();
      end else if (!dropped) begin
        if (bit_vld) begin
          mbits.push_back(bit_in);
          quiet = 0;
        end else begin
          quiet++;
          if (quiet == TO) begin
            e_len   = 1'b1;
            dropped = 1;
          end
        end
      end
      if (err_cnt_clr) e_cnt = 0;
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("cmp_rx_vld", {31'd0, rx_vld}, {31'd0, e_vld});
      chk("cmp_crc_err", {31'd0, crc_err}, {31'd0, e_crc});
      chk("cmp_len_err", {31'd0, len_err}, {31'd0, e_len});
      chk("cmp_busy", {31'd0, busy}, {31'd0, in_frame});
      chk("cmp_rx_data", {16'd0, rx_data}, {16'd0, e_data});
      chk("cmp_err_cnt", {24'd0, crc_err_cnt}, e_cnt);
    end
  end

  // Event log of DUT result pulses: 1=rx_vld, 2=crc_err, 3=len_err
  int          ev_kind[$];
  logic [15:0] ev_data[$];
  int          ev_cyc[$];
  int          ev_cnt[$];

  initial forever begin
    @(negedge clk);
    if (rst_n && (rx_vld || crc_err || len_err)) begin
      ev_kind.push_back(rx_vld ? 1 : (crc_err ? 2 : 3));
      ev_data.push_back(rx_data);
      ev_cyc.push_back(cyc);
      ev_cnt.push_back(int'(crc_err_cnt));
    end
  end

  task automatic ev_clear();
    ev_kind.delete(); ev_data.delete(); ev_cyc.delete(); ev_cnt.delete();
  endtask

  task automatic chk_ev(input string nm, input int idx, input int kind, input logic [15:0] data);
    int          k;
    logic [15:0] d;
    k = (idx < ev_kind.size()) ? ev_kind[idx] : 0;
    d = (idx < ev_kind.size()) ? ev_data[idx] : 16'h0;
    chk({nm, "_kind"}, k, kind);
    chk({nm, "_data"}, {16'd0, d}, {16'd0, data});
  endtask

  task automatic idle(input int n, input bit noise);
    repeat (n) begin
      @(negedge clk);
      cs_n        = 1'b1;
      bit_vld     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bit_in      = 1'($urandom_range(0, 1));
      err_cnt_clr = noise ? ($urandom_range(0, 15) == 0) : 1'b0;
    end
  endtask

  // gap < 0 picks a random 0..3 bit-less cycles before each bit
  task automatic send_frame(input logic [23:0] w, input int n, input int gap,
                            input bit close, input bit clr);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        @(negedge clk);
        cs_n = 1'b0; bit_vld = 1'b0; err_cnt_clr = 1'b0;
      end
      @(negedge clk);
      cs_n = 1'b0; bit_vld = 1'b1; err_cnt_clr = 1'b0;
      bit_in = (i < 24) ? w[23 - i] : 1'($urandom_range(0, 1));
    end
    if (n == 0) begin
      repeat (2) begin
        @(negedge clk);
        cs_n = 1'b0; bit_vld = 1'b0; err_cnt_clr = 1'b0;
      end
    end
    if (close) begin
      @(negedge clk);
      cs_n = 1'b1; bit_vld = 1'b0; err_cnt_clr = clr;
      close_cyc = cyc;
    end
  endtask

  initial begin
    logic [15:0] p;
    logic [23:0] w;
    int          n, kind;

    rst_n = 1'b0; cs_n = 1'b1; bit_vld = 1'b0; bit_in = 1'b0; err_cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", {16'd0, rx_data}, 32'h0);
    chk("rst_rx_vld", {31'd0, rx_vld}, 32'h0);
    chk("rst_crc_err", {31'd0, crc_err}, 32'h0);
    chk("rst_len_err", {31'd0, len_err}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_err_cnt", {24'd0, crc_err_cnt}, 32'h0);
    rst_n = 1'b1;

    chk("ref_crc_0000", {24'd0, ref_crc(16'h0000)}, 32'hB8);
    chk("ref_crc_ffff", {24'd0, ref_crc(16'hFFFF)}, 32'h42);

    // Good frame, bit every 3rd cycle
    idle(2, 0); ev_clear();
    send_frame(24'h0000B8, 24, 2, 1, 0);
    idle(3, 0);
    chk("good0_count", ev_kind.size(), 1);
    chk_ev("good0", 0, 1, 16'h0000);
    chk("good0_latency", (ev_cyc.size() > 0) ? ev_cyc[0] - close_cyc : -1, 1);

    // Good then bad CRC
    ev_clear();
    send_frame(24'hFFFF42, 24, 0, 1, 0);
    idle(3, 0);
    send_frame(24'h123400, 24, 1, 1, 0);
    idle(3, 0);
    chk("ffff_then_bad_count", ev_kind.size(), 2);
    chk_ev("goodffff", 0, 1, 16'hFFFF);
    chk_ev("badcrc", 1, 2, 16'hFFFF);
    chk("badcrc_cnt", {24'd0, crc_err_cnt}, 1);

    // Length errors: 23, 25, 0 bits
    ev_clear();
    send_frame(24'h0000B8, 23, 0, 1, 0); idle(2, 0);
    send_frame(24'h0000B8, 25, 0, 1, 0); idle(2, 0);
    send_frame(24'h0000B8, 0, 0, 1, 0);  idle(2, 0);
    chk("len_count", ev_kind.size(), 3);
    chk_ev("len23", 0, 3, 16'hFFFF);
    chk_ev("len25", 1, 3, 16'hFFFF);
    chk_ev("len0", 2, 3, 16'hFFFF);

    // Timeout, then bits ignored in abort
    ev_clear();
    send_frame(24'hA5A5A5, 10, 0, 0, 0);
    repeat (TO) begin
      @(negedge clk);
      cs_n = 1'b0; bit_vld = 1'b0;
    end
    chk("to_not_early", {31'd0, len_err}, 32'h0);
    @(negedge clk);
    chk("to_len_err", {31'd0, len_err}, 32'h1);
    chk("to_busy", {31'd0, busy}, 32'h1);
    repeat (30) begin
      bit_vld = 1'b1; bit_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    cs_n = 1'b1; bit_vld = 1'b0;
    idle(3, 0);
    chk("to_busy_after", {31'd0, busy}, 32'h0);
    chk("to_count", ev_kind.size(), 1);

    // Back-to-back with one cs_n-high cycle
    ev_clear();
    send_frame(24'h0000B8, 24, 0, 1, 0);
    send_frame(24'hFFFF42, 24, 0, 1, 0);
    idle(3, 0);
    chk("b2b_count", ev_kind.size(), 2);
    chk_ev("b2b_a", 0, 1, 16'h0000);
    chk_ev("b2b_b", 1, 1, 16'hFFFF);
    chk("b2b_latency", (ev_cyc.size() > 1) ? ev_cyc[1] - close_cyc : -1, 1);

    // Reset mid-frame
    ev_clear();
    send_frame(24'h123456, 12, 0, 0, 0);
    @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    chk("mid_rst_rx_data", {16'd0, rx_data}, 32'h0);
    chk("mid_rst_cnt", {24'd0, crc_err_cnt}, 32'h0);
    chk("mid_rst_pulses", {29'd0, rx_vld, crc_err, len_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; cs_n = 1'b1; bit_vld = 1'b0;
    idle(3, 0);
    chk("mid_rst_no_event", ev_kind.size(), 0);

    // Counter saturation, then clear coincident with crc_err
    ev_clear();
    for (int f = 0; f < 300; f++) begin
      p = 16'($urandom);
      send_frame({p, ref_crc(p) ^ 8'h5A}, 24, 0, 1, 0);
    end
    idle(2, 0);
    chk("sat_events", ev_kind.size(), 300);
    chk("sat_cnt", {24'd0, crc_err_cnt}, CNT_MAX);
    ev_clear();
    send_frame(24'h123400, 24, 0, 1, 1);
    idle(2, 0);
    chk_ev("clr_bad", 0, 2, 16'h0000);
    chk("clr_cnt_at_pulse", (ev_cnt.size() > 0) ? ev_cnt[0] : -1, 0);

    // Randomized frames
    for (int f = 0; f < 250; f++) begin
      idle($urandom_range(0, 3), 1);
      p    = 16'($urandom);
      kind = $urandom_range(0, 9);
      n    = 24;
      if (kind < 5) begin
        w = {p, ref_crc(p)};
      end else if (kind < 7) begin
        w = {p, ref_crc(p) ^ 8'(1 << $urandom_range(0, 7))};
      end else begin
        w = {p, ref_crc(p)};
        n = $urandom_range(0, 27);
        if (n == 24) n = 23;
      end
      send_frame(w, n, ($urandom_range(0, 1) == 1) ? -1 : 0, 1, ($urandom_range(0, 7) == 0));
    end
    idle(4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
